// File: rtl/homomorphic_addsub_stream.sv
// ---------------------------------------------------------------------------
// homomorphic_addsub_stream
//
// Streaming, two-stage pipelined homomorphic add/subtract of two LWE
// ciphertexts, PARALLEL coefficient lanes per beat, modulo an arbitrary
// ciphertext modulus Q (not restricted to powers of two).
//
// Stage S1 registers the raw W+1 bit sum or difference (the MSB of the
// difference is the borrow). Stage S2 registers the reduced result.
// A beat index travels with the data so that out_last and padding of lanes
// past the end of the vector come from the internal count, not from in_last.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat
//   in_op      in   0 = add, 1 = subtract (ct1 - ct2), sampled per beat
//   in_last    in   producer's final-beat marker (checked, not trusted)
//   ct1, ct2   in   lane-packed operands, lane i at [i*W +: W]
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts the result beat
//   out_data   out  lane-packed result mod Q
//   out_last   out  final beat of the ciphertext, from the internal counter
//   frame_err  out  sticky: in_last disagreed with the internal beat count
//   range_err  out  sticky: an accepted operand lane was >= Q
//                   (only present when HOMADD_RANGE_CHECK_EN is defined)
//
// Optional feature macro: HOMADD_RANGE_CHECK_EN
// ---------------------------------------------------------------------------
module homomorphic_addsub_stream #(
    parameter int CIPHERTEXT_MODULUS = 1000,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 3,
    parameter int PARALLEL           = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_op,
    input  logic                                   in_last,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]   ct1,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]   ct2,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]   out_data,
    output logic                                   out_last,
`ifdef HOMADD_RANGE_CHECK_EN
    output logic                                   range_err,
`endif
    output logic                                   frame_err
);

    localparam int W     = CIPHERTEXT_WIDTH;
    localparam int WP1   = CIPHERTEXT_WIDTH + 1;
    localparam int PW    = PARALLEL * CIPHERTEXT_WIDTH;
    localparam int BEATS = (DIMENSION + 1 + PARALLEL - 1) / PARALLEL;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Q needs W+1 bits because Q = 2**W is a legal modulus
    localparam logic [W:0]       Q_EXT    = WP1'(CIPHERTEXT_MODULUS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    logic             ready_en;
    logic [CNT_W-1:0] beat_cnt;

    logic             s1_full;
    logic             s1_op;
    logic [CNT_W-1:0] s1_idx;
    logic [W:0]       s1_raw [PARALLEL];

    logic [W:0]       raw_next [PARALLEL];
    logic [W:0]       red_lane [PARALLEL];
    logic [PW-1:0]    reduced;

    logic             s2_take;
    logic             s1_move;
    logic             in_fire;

    // Handshake: S2 can take when empty or draining this cycle; S1 can take
    // when empty or moving into S2. ready_en keeps in_ready low during reset
    // and until the first clock after release.
    always_comb begin
        s2_take  = !out_valid || out_ready;
        s1_move  = s1_full && s2_take;
        in_ready = ready_en && (!s1_full || s2_take);
        in_fire  = in_valid && in_ready;
    end

    // Raw lane arithmetic; the subtract result's MSB doubles as the borrow
    always_comb begin
        for (int i = 0; i < PARALLEL; i++) begin
            raw_next[i] = '0;
            if (in_op)
                raw_next[i] = {1'b0, ct1[i*W +: W]} - {1'b0, ct2[i*W +: W]};
            else
                raw_next[i] = {1'b0, ct1[i*W +: W]} + {1'b0, ct2[i*W +: W]};
        end
    end

    // Modular reduction of the S1 contents, plus zeroing of lanes whose
    // coefficient index falls past the end of the n+1 element vector
    always_comb begin
        reduced = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            red_lane[i] = s1_raw[i];
            if (s1_op) begin
                if (s1_raw[i][W])
                    red_lane[i] = s1_raw[i] + Q_EXT;
            end else begin
                if (s1_raw[i] >= Q_EXT)
                    red_lane[i] = s1_raw[i] - Q_EXT;
            end
            if (int'(s1_idx) * PARALLEL + i < DIMENSION + 1)
                reduced[i*W +: W] = red_lane[i][W-1:0];
        end
    end

    // Input-ready enable: low in reset, high from the first clock afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ready_en <= 1'b0;
        else
            ready_en <= 1'b1;
    end

    // Beat counter and sticky framing check against the producer's in_last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (in_fire) begin
            beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + 1'b1;
            if (in_last != (beat_cnt == LAST_IDX))
                frame_err <= 1'b1;
        end
    end

    // Stage S1: loads on accept, empties when it hands over to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_op   <= 1'b0;
            s1_idx  <= '0;
            for (int i = 0; i < PARALLEL; i++)
                s1_raw[i] <= '0;
        end else if (in_fire) begin
            s1_full <= 1'b1;
            s1_op   <= in_op;
            s1_idx  <= beat_cnt;
            for (int i = 0; i < PARALLEL; i++)
                s1_raw[i] <= raw_next[i];
        end else if (s1_move) begin
            s1_full <= 1'b0;
        end
    end

    // Stage S2: registered output; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (s1_move) begin
            out_valid <= 1'b1;
            out_data  <= reduced;
            out_last  <= (s1_idx == LAST_IDX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef HOMADD_RANGE_CHECK_EN
    logic range_hit;

    // Any accepted operand lane at or above Q flags the sticky range error
    always_comb begin
        range_hit = 1'b0;
        for (int i = 0; i < PARALLEL; i++) begin
            if ({1'b0, ct1[i*W +: W]} >= Q_EXT || {1'b0, ct2[i*W +: W]} >= Q_EXT)
                range_hit = 1'b1;
        end
    end

    // Sticky range error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            range_err <= 1'b0;
        else if (in_fire && range_hit)
            range_err <= 1'b1;
    end
`endif

endmodule

// File: doc/homomorphic_addsub_stream.md
Name: homomorphic_addsub_stream

Overview:
Streaming, pipelined homomorphic add/subtract of two LWE ciphertexts, PARALLEL coefficient lanes per beat, over an arbitrary (not only power-of-two) ciphertext modulus. Each ciphertext vector of DIMENSION+1 coefficients arrives as a burst of beats under valid/ready handshake. Results leave with last-beat framing. It is the backpressure-capable successor to the combinational lane adder and sits between the ciphertext buffer and the decrypt/bootstrap path.

Parameters:
CIPHERTEXT_MODULUS, 1000, modulus Q; 2 <= Q <= 2**CIPHERTEXT_WIDTH
CIPHERTEXT_WIDTH, 10, bits per coefficient
DIMENSION, 3, LWE dimension n; vector length is n+1
PARALLEL, 2, coefficient lanes per beat
BEATS, ceil((DIMENSION+1)/PARALLEL), derived localparam; beats per ciphertext

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_op  in  1  0 = add, 1 = subtract (ct1 - ct2); sampled per beat
in_last  in  1  producer's marker for the final beat of a ciphertext
ct1  in  PARALLEL*CIPHERTEXT_WIDTH  lane-packed operand 1; lane i at bits [i*W +: W]
ct2  in  PARALLEL*CIPHERTEXT_WIDTH  lane-packed operand 2
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts the result beat
out_data  out  PARALLEL*CIPHERTEXT_WIDTH  lane-packed result mod Q
out_last  out  1  final beat of the ciphertext, from the internal counter
frame_err  out  1  sticky; in_last disagreed with the internal beat count

Behaviour:
- Reset, asynchronous and immediate: in_ready=0 while rst_n=0, 1 from the first clk after release; out_valid=0, out_data=0, out_last=0, frame_err=0. Pipeline is emptied, beat counter=0.
- Reset mid-burst discards all in-flight beats. The next accepted beat is beat 0.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Pipeline has 2 registered stages, S1 and S2. Latency is 2 cycles from accept to out_valid with no stall.
- S1 raw: add s = a+b, width W+1. Subtract d = a-b with a borrow flag.
- S2 reduce: add gives s>=Q ? s-Q : s. Subtract gives borrow ? d+Q : d. The result is truncated to W bits.
- Operands are required < Q. For Q = 2**W this equals natural W-bit wraparound.
- Each stage holds its data when the next stage is occupied and not draining. The stage loads when it is empty or draining in the same cycle.
- in_ready = !S1_full || S2 can take S1. There is no combinational path from out_ready to out_data. in_ready may depend combinationally on out_ready.
- Full throughput is 1 beat/cycle with out_ready held high. Nothing is dropped or duplicated under any out_ready pattern.
- Beat counter increments on accept and wraps BEATS-1 -> 0. Beat index travels with data.
- out_last=1 when the beat index is BEATS-1.
- On the final beat, lanes whose coefficient index is >= DIMENSION+1 output 0.
- frame_err is set on an accepted beat where in_last != (counter==BEATS-1). It stays set until reset. The data path is unaffected.
- Accept and output transfer in the same cycle are legal. Occupancy is unchanged.

Optional Feature:
HOMADD_RANGE_CHECK_EN:
- Defined: adds output range_err, 1 bit, sticky, reset 0. It is set when any accepted lane operand of ct1 or ct2 is >= Q. The result is still computed per the formulas.
- Undefined: no port and no comparators. Out-of-range operands give unspecified but deterministic values.

Test Plan:
- Add, 2-beat ct, Q=1000. Beat0 ct1={102,72}, ct2={356,23}; beat1 ct1={600,3}, ct2={431,10}, in_last on beat1. Expect {458,95} with out_last=0, then {31,13} with out_last=1, 2-cycle latency.
- Subtract, in_op=1. ct1={3,999}, ct2={10,999}, then ct1={0,500}, ct2={1,200}. Expect {993,0}, then {999,300}.
- Backpressure: stream 8 random beats and toggle out_ready pseudo-randomly. Output sequence equals the golden (a±b) mod Q. in_ready drops when both stages are full.
- Framing: assert in_last on beat0. frame_err rises the cycle after that accept and stays 1 through later correct frames.
- Padding, DIMENSION=2, PARALLEL=2: beat1 lane1 inputs {500,600}. out_data lane1 = 0, out_last=1.
- Reset mid-burst: assert rst_n=0 after beat0 accept. Outputs go 0 immediately. After release, the next beat carries out_last=0 and is treated as beat 0. With HOMADD_RANGE_CHECK_EN, ct1 lane=1000 sets range_err.
